// File: rtl/pll_rst_seq_pkg.sv
// Shared types and helpers for the PLL reset/lock sequencer.
package pll_rst_seq_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    RST_ASSERT = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    RUN        = 3'd3,
    FAIL       = 3'd4
  } state_t;

  localparam int LOST_CNT_W  = 8;
  localparam int RETRY_CNT_W = 2;

  // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Increment that sticks at all-ones, so lock-loss history never wraps.
  function automatic logic [LOST_CNT_W-1:0] sat_inc(input logic [LOST_CNT_W-1:0] v);
    return (v == {LOST_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the clk domain.
module pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Capture stage followed by a settle stage; both clear to "not locked".
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset/lock initiator: pulses pll_rst, qualifies lock over a stability
// window, retries on timeout, and gates the downstream synchronous reset.
//
// Control handshake: restart is a single-cycle request sampled on a clk edge;
// it has no acknowledge and is honoured in every state (rst wins over it).
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int LOCK_STABLE_CYC  = 256,
  parameter int MAX_RETRY        = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   restart,
  input  logic                   pll_lock,
  output logic                   pll_rst,
  output logic                   sys_rst,
  output logic                   ready,
  output logic                   err,
  output logic [LOST_CNT_W-1:0]  lock_lost_cnt,
  output logic [RETRY_CNT_W-1:0] retry_cnt
);

  // tmo_cnt times both the reset pulse and the lock timeout, so it is sized
  // for whichever of the two is longer.
  localparam int TMO_SPAN = (LOCK_TIMEOUT_CYC > RST_PULSE_CYC) ? LOCK_TIMEOUT_CYC
                                                                : RST_PULSE_CYC;
  localparam int TMO_W    = cnt_w(TMO_SPAN);
  localparam int STB_W    = cnt_w(LOCK_STABLE_CYC);

  localparam logic [TMO_W-1:0]       PULSE_LAST = TMO_W'(RST_PULSE_CYC - 1);
  localparam logic [TMO_W-1:0]       TMO_LAST   = TMO_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [STB_W-1:0]       STB_LAST   = STB_W'(LOCK_STABLE_CYC - 1);
  localparam logic [RETRY_CNT_W-1:0] RETRY_MAX  = RETRY_CNT_W'(MAX_RETRY);

  state_t                 state;
  state_t                 state_nxt;
  logic [TMO_W-1:0]       tmo_cnt;
  logic [TMO_W-1:0]       tmo_nxt;
  logic [STB_W-1:0]       stb_cnt;
  logic [STB_W-1:0]       stb_nxt;
  logic [RETRY_CNT_W-1:0] retry_nxt;
  logic [LOST_CNT_W-1:0]  lost_nxt;
  logic                   lock_s;
  logic                   lock_drop;

  pll_lock_sync u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // A drop of synchronized lock while running counts as a loss even when a
  // restart arrives on the same edge.
  assign lock_drop = (state == RUN) && !lock_s;

  // Next-state, counter and retry/loss bookkeeping.
  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo_cnt;
    stb_nxt   = stb_cnt;
    retry_nxt = retry_cnt;
    lost_nxt  = lock_lost_cnt;

    if (restart) begin
      state_nxt = RST_ASSERT;
      tmo_nxt   = '0;
      stb_nxt   = '0;
      retry_nxt = '0;
      if (lock_drop) lost_nxt = sat_inc(lock_lost_cnt);
    end else begin
      case (state)
        RST_ASSERT: begin
          if (tmo_cnt == PULSE_LAST) begin
            state_nxt = WAIT_LOCK;
            tmo_nxt   = '0;
          end else begin
            tmo_nxt = tmo_cnt + 1'b1;
          end
        end

        WAIT_LOCK, STABLE: begin
          // The timeout runs from the end of the pulse and is not restarted
          // by lock chatter; it also wins over a same-edge qualification.
          if (tmo_cnt == TMO_LAST) begin
            retry_nxt = retry_cnt + 1'b1;
            tmo_nxt   = '0;
            state_nxt = (retry_nxt == RETRY_MAX) ? FAIL : RST_ASSERT;
          end else begin
            tmo_nxt = tmo_cnt + 1'b1;
            if (state == WAIT_LOCK) begin
              if (lock_s) begin
                state_nxt = STABLE;
                stb_nxt   = '0;
              end
            end else if (!lock_s) begin
              state_nxt = WAIT_LOCK;
            end else if (stb_cnt == STB_LAST) begin
              state_nxt = RUN;
              retry_nxt = '0;
            end else begin
              stb_nxt = stb_cnt + 1'b1;
            end
          end
        end

        RUN: begin
          if (!lock_s) begin
            lost_nxt  = sat_inc(lock_lost_cnt);
            state_nxt = RST_ASSERT;
            tmo_nxt   = '0;
          end
        end

        FAIL: begin
          state_nxt = FAIL;
        end

        default: begin
          state_nxt = RST_ASSERT;
          tmo_nxt   = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs; outputs are decoded from the
  // next state so they change on the same edge as the transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RST_ASSERT;
      tmo_cnt       <= '0;
      stb_cnt       <= '0;
      retry_cnt     <= '0;
      lock_lost_cnt <= '0;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_nxt;
      tmo_cnt       <= tmo_nxt;
      stb_cnt       <= stb_nxt;
      retry_cnt     <= retry_nxt;
      lock_lost_cnt <= lost_nxt;
      pll_rst       <= (state_nxt == RST_ASSERT);
      sys_rst       <= (state_nxt != RUN);
      ready         <= (state_nxt == RUN);
      err           <= (state_nxt == FAIL);
    end
  end

  // ready and sys_rst are always complementary.
  a_ready_vs_sys_rst: assert property (@(posedge clk) disable iff (rst) ready != sys_rst);

endmodule
